// File: rtl/spi_ram_arbiter.sv
// Arbitrates a single-port RAM between an SPI command stream and a host port.
// Optional ARB_AUTOINC_EN: SPI wr/rd addresses post-increment on each granted access.
module spi_ram_arbiter #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        spi_rx_data,
    input  logic              spi_rx_valid,
    output logic [7:0]        spi_tx_data,
    output logic              spi_tx_valid,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [7:0]        host_wdata,
    output logic              host_ack,
    output logic [7:0]        host_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic              err_ovf
);

    localparam logic [1:0] CMD_WADDR = 2'b00;
    localparam logic [1:0] CMD_RADDR = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              pend_valid_q, pend_valid_d;
    logic              pend_we_q, pend_we_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [7:0]        pend_data_q, pend_data_d;
    logic              last_spi_q, last_spi_d;
    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]        ram_wdata_q, ram_wdata_d;
    logic [7:0]        spi_tx_data_q, spi_tx_data_d;
    logic              spi_tx_valid_q, spi_tx_valid_d;
    logic              host_ack_q, host_ack_d;
    logic [7:0]        host_rdata_q, host_rdata_d;
    logic              err_ovf_q, err_ovf_d;

    logic [1:0]        cmd;
    logic [ADDR_W-1:0] rx_addr;
    logic              host_pend;
    logic              grant_spi;
    logic              grant_host;
    logic              wr_inc;
    logic              rd_inc;
    logic [ADDR_W-1:0] wr_now;
    logic [ADDR_W-1:0] rd_now;

    assign cmd     = spi_rx_data[9:8];
    assign rx_addr = spi_rx_data[ADDR_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            wr_addr_q      <= '0;
            rd_addr_q      <= '0;
            pend_valid_q   <= 1'b0;
            pend_we_q      <= 1'b0;
            pend_addr_q    <= '0;
            pend_data_q    <= '0;
            last_spi_q     <= 1'b0;
            ram_en_q       <= 1'b0;
            ram_we_q       <= 1'b0;
            ram_addr_q     <= '0;
            ram_wdata_q    <= '0;
            spi_tx_data_q  <= '0;
            spi_tx_valid_q <= 1'b0;
            host_ack_q     <= 1'b0;
            host_rdata_q   <= '0;
            err_ovf_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_addr_q      <= wr_addr_d;
            rd_addr_q      <= rd_addr_d;
            pend_valid_q   <= pend_valid_d;
            pend_we_q      <= pend_we_d;
            pend_addr_q    <= pend_addr_d;
            pend_data_q    <= pend_data_d;
            last_spi_q     <= last_spi_d;
            ram_en_q       <= ram_en_d;
            ram_we_q       <= ram_we_d;
            ram_addr_q     <= ram_addr_d;
            ram_wdata_q    <= ram_wdata_d;
            spi_tx_data_q  <= spi_tx_data_d;
            spi_tx_valid_q <= spi_tx_valid_d;
            host_ack_q     <= host_ack_d;
            host_rdata_q   <= host_rdata_d;
            err_ovf_q      <= err_ovf_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        wr_addr_d      = wr_addr_q;
        rd_addr_d      = rd_addr_q;
        pend_valid_d   = pend_valid_q;
        pend_we_d      = pend_we_q;
        pend_addr_d    = pend_addr_q;
        pend_data_d    = pend_data_q;
        last_spi_d     = last_spi_q;
        ram_en_d       = 1'b0;
        ram_we_d       = ram_we_q;
        ram_addr_d     = ram_addr_q;
        ram_wdata_d    = ram_wdata_q;
        spi_tx_data_d  = spi_tx_data_q;
        spi_tx_valid_d = 1'b0;
        host_ack_d     = 1'b0;
        host_rdata_d   = host_rdata_q;
        err_ovf_d      = err_ovf_q;

        // The host still holds req during its ack cycle; mask it so it is not re-granted.
        host_pend  = host_req & ~host_ack_q;
        grant_spi  = (state_q == IDLE) && pend_valid_q && (!host_pend || !last_spi_q);
        grant_host = (state_q == IDLE) && host_pend && !grant_spi;

`ifdef ARB_AUTOINC_EN
        wr_inc = grant_spi && pend_we_q;
        rd_inc = grant_spi && !pend_we_q;
`else
        wr_inc = 1'b0;
        rd_inc = 1'b0;
`endif
        // Address seen by a command arriving this cycle includes this cycle's increment.
        wr_now = wr_inc ? wr_addr_q + ADDR_W'(1) : wr_addr_q;
        rd_now = rd_inc ? rd_addr_q + ADDR_W'(1) : rd_addr_q;
        wr_addr_d = wr_now;
        rd_addr_d = rd_now;

        if (grant_spi) begin
            pend_valid_d = 1'b0;
        end

        if (spi_rx_valid) begin
            if (cmd == CMD_WADDR) begin
                wr_addr_d = rx_addr;
            end else if (cmd == CMD_RADDR) begin
                rd_addr_d = rx_addr;
            end else if (!pend_valid_q || grant_spi) begin
                pend_valid_d = 1'b1;
                pend_we_d    = ~cmd[1];
                pend_addr_d  = cmd[1] ? rd_now : wr_now;
                pend_data_d  = spi_rx_data[7:0];
            end else begin
                err_ovf_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (grant_spi || grant_host) begin
                    state_d     = ACCESS;
                    ram_en_d    = 1'b1;
                    last_spi_d  = grant_spi;
                    ram_we_d    = grant_spi ? pend_we_q : host_we;
                    ram_addr_d  = grant_spi ? pend_addr_q : host_addr;
                    ram_wdata_d = grant_spi ? pend_data_q : host_wdata;
                end
            end
            ACCESS: begin
                if (ram_we_q) begin
                    state_d    = IDLE;
                    host_ack_d = ~last_spi_q;
                end else begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                state_d = IDLE;
                if (last_spi_q) begin
                    spi_tx_data_d  = ram_rdata;
                    spi_tx_valid_d = 1'b1;
                end else begin
                    host_rdata_d = ram_rdata;
                    host_ack_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign spi_tx_data  = spi_tx_data_q;
    assign spi_tx_valid = spi_tx_valid_q;
    assign host_ack     = host_ack_q;
    assign host_rdata   = host_rdata_q;
    assign ram_en       = ram_en_q;
    assign ram_we       = ram_we_q;
    assign ram_addr     = ram_addr_q;
    assign ram_wdata    = ram_wdata_q;
    assign err_ovf      = err_ovf_q;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed self-checking bench for spi_ram_arbiter with a behavioural RAM model.
module tb_spi_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] spi_rx_data;
    logic       spi_rx_valid;
    logic [7:0] spi_tx_data;
    logic       spi_tx_valid;
    logic       host_req;
    logic       host_we;
    logic [7:0] host_addr;
    logic [7:0] host_wdata;
    logic       host_ack;
    logic [7:0] host_rdata;
    logic       ram_en;
    logic       ram_we;
    logic [7:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;
    logic       err_ovf;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mem [256];
    logic [7:0] en_data [16];
    int         en_count = 0;

    spi_ram_arbiter #(.ADDR_W(8)) dut (
        .clk(clk), .rst(rst),
        .spi_rx_data(spi_rx_data), .spi_rx_valid(spi_rx_valid),
        .spi_tx_data(spi_tx_data), .spi_tx_valid(spi_tx_valid),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: read data valid the cycle after an enabled read.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
            if (en_count < 16) en_data[en_count] <= ram_wdata;
            en_count <= en_count + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic spi_send(input logic [9:0] w);
        spi_rx_data  = w;
        spi_rx_valid = 1'b1;
        tick();
        spi_rx_valid = 1'b0;
    endtask

    task automatic host_access(input logic we, input logic [7:0] a, input logic [7:0] wd,
                               output int lat, output logic [7:0] rd);
        host_req   = 1'b1;
        host_we    = we;
        host_addr  = a;
        host_wdata = wd;
        lat = 0;
        while (!host_ack && lat < 20) begin
            tick();
            lat++;
        end
        rd = host_rdata;
        host_req = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] vals [9];
        vals = '{8'(ram_en), 8'(ram_we), ram_addr, ram_wdata, 8'(spi_tx_valid),
                 spi_tx_data, 8'(host_ack), host_rdata, 8'(err_ovf)};
        for (int i = 0; i < 9; i++) begin
            n_cmp++;
            if (vals[i] !== 8'h00) begin
                n_bad++;
                $display("FAIL reset_out%0d: got %0h expected 0", i, vals[i]);
            end
        end
    endtask

    task automatic test_spi_rw();
        spi_send(10'h005);
        spi_send(10'h1A5);
        spi_send(10'h205);
        spi_send(10'h300);
        for (int k = 1; k < 4; k++) begin
            n_cmp++;
            if (spi_tx_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL spi_tx_early cycle %0d: got %b expected 0", k, spi_tx_valid);
            end
            tick();
        end
        n_cmp++;
        if (spi_tx_valid !== 1'b1 || spi_tx_data !== 8'hA5) begin
            n_bad++;
            $display("FAIL spi_read_lat4: got v=%b d=%0h expected v=1 d=a5", spi_tx_valid, spi_tx_data);
        end
        tick();
        n_cmp++;
        if (spi_tx_valid !== 1'b0 || spi_tx_data !== 8'hA5) begin
            n_bad++;
            $display("FAIL spi_tx_hold: got v=%b d=%0h expected v=0 d=a5", spi_tx_valid, spi_tx_data);
        end
        n_cmp++;
        if (mem[5] !== 8'hA5) begin
            n_bad++;
            $display("FAIL spi_ram_write: got %0h expected a5", mem[5]);
        end
    endtask

    task automatic test_host_rw();
        int lat;
        logic [7:0] rd;
        host_access(1'b1, 8'h10, 8'h3C, lat, rd);
        n_cmp++;
        if (lat !== 2) begin
            n_bad++;
            $display("FAIL host_write_lat: got %0d expected 2", lat);
        end
        tick();
        n_cmp++;
        if (host_ack !== 1'b0 || mem[8'h10] !== 8'h3C) begin
            n_bad++;
            $display("FAIL host_write_data: got ack=%b mem=%0h expected ack=0 mem=3c", host_ack, mem[8'h10]);
        end
        host_access(1'b0, 8'h10, 8'h00, lat, rd);
        n_cmp++;
        if (lat !== 3 || rd !== 8'h3C) begin
            n_bad++;
            $display("FAIL host_read: got lat=%0d d=%0h expected lat=3 d=3c", lat, rd);
        end
        tick();
    endtask

    task automatic test_round_robin();
        int w;
        logic [7:0] exp_log [5];
        exp_log = '{8'h51, 8'hC1, 8'h52, 8'hC2, 8'h53};
        spi_send(10'h030);
        tick();
        en_count = 0;
        spi_rx_data = 10'h151; spi_rx_valid = 1'b1;
        tick();
        spi_rx_valid = 1'b0;
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h20; host_wdata = 8'hC1;
        tick();
        spi_rx_data = 10'h152; spi_rx_valid = 1'b1;
        tick();
        spi_rx_valid = 1'b0;
        w = 0;
        while (!host_ack && w < 20) begin tick(); w++; end
        host_req = 1'b0;
        n_cmp++;
        if (w !== 2) begin
            n_bad++;
            $display("FAIL rr_ack1_wait: got %0d expected 2", w);
        end
        tick();
        host_req = 1'b1; host_wdata = 8'hC2;
        spi_rx_data = 10'h153; spi_rx_valid = 1'b1;
        tick();
        spi_rx_valid = 1'b0;
        w = 0;
        while (!host_ack && w < 20) begin tick(); w++; end
        host_req = 1'b0;
        n_cmp++;
        if (w !== 2) begin
            n_bad++;
            $display("FAIL rr_ack2_wait: got %0d expected 2", w);
        end
        repeat (6) tick();
        n_cmp++;
        if (en_count !== 5) begin
            n_bad++;
            $display("FAIL rr_en_count: got %0d expected 5", en_count);
        end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (en_data[i] !== exp_log[i]) begin
                n_bad++;
                $display("FAIL rr_grant%0d: got %0h expected %0h", i, en_data[i], exp_log[i]);
            end
        end
    endtask

    task automatic test_autoinc();
        spi_send(10'h0FF);
        spi_send(10'h111);
        spi_send(10'h122);
        repeat (6) tick();
`ifdef ARB_AUTOINC_EN
        n_cmp++;
        if (mem[8'hFF] !== 8'h11 || mem[8'h00] !== 8'h22) begin
            n_bad++;
            $display("FAIL autoinc_wrap: got ff=%0h 00=%0h expected ff=11 00=22", mem[8'hFF], mem[8'h00]);
        end
`else
        n_cmp++;
        if (mem[8'hFF] !== 8'h22 || mem[8'h00] !== 8'h00) begin
            n_bad++;
            $display("FAIL fixed_addr: got ff=%0h 00=%0h expected ff=22 00=0", mem[8'hFF], mem[8'h00]);
        end
`endif
        n_cmp++;
        if (err_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL grant_same_cycle_ovf: got %b expected 0", err_ovf);
        end
    endtask

    task automatic test_overflow();
        spi_send(10'h040);
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
        tick();
        spi_rx_data = 10'h171; spi_rx_valid = 1'b1;
        tick();
        spi_rx_data = 10'h172;
        tick();
        spi_rx_valid = 1'b0;
        n_cmp++;
        if (host_ack !== 1'b1 || host_rdata !== 8'h3C || err_ovf !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_cycle3: got ack=%b d=%0h ovf=%b expected ack=1 d=3c ovf=1",
                     host_ack, host_rdata, err_ovf);
        end
        host_req = 1'b0;
        repeat (6) tick();
        n_cmp++;
        if (mem[8'h40] !== 8'h71 || mem[8'h41] === 8'h72 || err_ovf !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_drop: got m40=%0h m41=%0h ovf=%b expected m40=71 m41!=72 ovf=1",
                     mem[8'h40], mem[8'h41], err_ovf);
        end
    endtask

    task automatic test_reset_capture();
        int lat;
        int acks;
        logic [7:0] rd;
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
        tick();
        tick();
        rst = 1'b1;
        #1;
        host_req = 1'b0;
        test_reset();
        tick();
        rst = 1'b0;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            if (host_ack) acks++;
            tick();
        end
        n_cmp++;
        if (acks !== 0) begin
            n_bad++;
            $display("FAIL aborted_ack: got %0d acks expected 0", acks);
        end
        host_access(1'b0, 8'h10, 8'h00, lat, rd);
        n_cmp++;
        if (lat !== 3 || rd !== 8'h3C) begin
            n_bad++;
            $display("FAIL post_reset_read: got lat=%0d d=%0h expected lat=3 d=3c", lat, rd);
        end
        tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        ram_rdata    = 8'h00;
        rst          = 1'b1;
        spi_rx_data  = 10'h000;
        spi_rx_valid = 1'b0;
        host_req     = 1'b0;
        host_we      = 1'b0;
        host_addr    = 8'h00;
        host_wdata   = 8'h00;
        tick();
        tick();
        test_reset();
        rst = 1'b0;
        tick();
        test_spi_rw();
        test_host_rw();
        test_round_robin();
        test_autoinc();
        test_overflow();
        test_reset_capture();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_ram_arbiter.md
SPI_RAM_ARBITER -- requirements
Module: spi_ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, RAM address width; legal range 1..8; SPI address payload = spi_rx_data[ADDR_W-1:0].
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 spi_rx_data  in  10  SPI slave word: [9:8] command, [7:0] payload.
REQ-005 spi_rx_valid  in  1  one-cycle strobe qualifying spi_rx_data.
REQ-006 spi_tx_data  out  8  read data returned to SPI slave.
REQ-007 spi_tx_valid  out  1  one-cycle strobe qualifying spi_tx_data.
REQ-008 host_req  in  1  host access request, level, held until host_ack.
REQ-009 host_we  in  1  host write (1) / read (0), stable while host_req high.
REQ-010 host_addr  in  ADDR_W  host address, stable while host_req high.
REQ-011 host_wdata  in  8  host write data, stable while host_req high.
REQ-012 host_ack  out  1  one-cycle completion pulse.
REQ-013 host_rdata  out  8  host read data, valid with host_ack on reads.
REQ-014 ram_en / ram_we  out  1 each  RAM enable / write enable.
REQ-015 ram_addr / ram_wdata  out  ADDR_W / 8  RAM address / write data.
REQ-016 ram_rdata  in  8  RAM read data, valid the cycle after an enabled read.
REQ-017 err_ovf  out  1  sticky SPI command overflow flag.

Function
REQ-018 SPI commands: 00 load wr_addr; 10 load rd_addr (both take effect next cycle, no RAM access); 01 write payload to RAM[wr_addr]; 11 read RAM[rd_addr].
REQ-019 Commands 01/11 post into a one-entry SPI pending register capturing op, address and payload at strobe time.
REQ-020 spi_rx_valid with 01/11 while the pending register is full: command dropped, err_ovf set; 00/10 always accepted.
REQ-021 FSM states IDLE, ACCESS, CAPTURE; IDLE->ACCESS when any request pending; ACCESS->IDLE on write, ACCESS->CAPTURE on read; CAPTURE->IDLE always.
REQ-022 In IDLE, winner selected and ram_we/ram_addr/ram_wdata registered; ram_en high only in ACCESS, exactly one cycle.
REQ-023 Arbitration round-robin: on simultaneous SPI and host requests, grant the requester not granted last; last-grant bit resets to host (SPI wins first tie); a lone requester always wins.
REQ-024 Write completion: host_ack pulses the cycle after ACCESS; SPI writes produce no response strobe.
REQ-025 Read completion: ram_rdata captured in CAPTURE; spi_tx_data+spi_tx_valid or host_rdata+host_ack the following cycle.
REQ-026 Latency from idle: spi_rx_valid (cycle 0) -> spi_tx_valid cycle 4; host_req rising (cycle 0) -> read ack cycle 3, write ack cycle 2.
REQ-027 SPI pending cleared when granted; a new 01/11 strobe in the same cycle as the grant is accepted, not an overflow.
REQ-028 host_req dropped before ack is a protocol violation; behaviour undefined, not checked.
REQ-029 spi_tx_data and host_rdata hold last value between strobes.

Reset
REQ-030 rst asserted: immediately state=IDLE, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, spi_tx_valid=0, spi_tx_data=0, host_ack=0, host_rdata=0, err_ovf=0, wr_addr=rd_addr=0, pending cleared, last-grant=host.
REQ-031 Reset mid-ACCESS/CAPTURE aborts the access; no ack or tx strobe issued for it after release.

Configuration
REQ-032 Macro ARB_AUTOINC_EN defined: wr_addr increments after each granted SPI write, rd_addr after each granted SPI read, wrapping 2^ADDR_W-1 -> 0; 00/10 in the same cycle as an increment take priority.
REQ-033 ARB_AUTOINC_EN undefined: wr_addr/rd_addr change only on 00/10 commands.

Verification
REQ-034 SPI 0x005, 0x1A5, 0x205, 0x300 -> RAM[5]=0xA5 written, spi_tx_data=0xA5 with spi_tx_valid 4 cycles after last strobe.
REQ-035 Host write addr 0x10 data 0x3C then read 0x10 -> write ack cycle 2, read ack cycle 3 with host_rdata=0x3C.
REQ-036 SPI 01 and host_req in same cycle after reset, repeated -> grants SPI, host, SPI, host; one ram_en pulse per grant.
REQ-037 Two SPI 0x1xx strobes on consecutive cycles while host holds the RAM -> second dropped, err_ovf=1 until reset.
REQ-038 ARB_AUTOINC_EN: 0x0FF then 0x111, 0x122 -> RAM[0xFF]=0x11, RAM[0x00]=0x22; undefined: RAM[0xFF]=0x22.
REQ-039 rst pulsed during CAPTURE of host read -> no host_ack, all outputs at reset values, next request serviced normally.
